// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit with fixed 34-cycle latency
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

    logic              accept, signed_a, signed_b, sgn_a_in, sgn_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, quo, rem, fix_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    // Operand decode at accept time: signedness per funct3, then magnitudes
    always_comb begin
        accept   = (state_q == S_IDLE || state_q == S_DONE) && start && !flush;
        signed_a = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        signed_b = op[2] ? ~op[0] : ~op[1];
        sgn_a_in = a[XLEN-1] & signed_a;
        sgn_b_in = b[XLEN-1] & signed_b;
        mag_a_in = sgn_a_in ? -a : a;
        mag_b_in = sgn_b_in ? -b : b;
    end

    // One iteration of shift-add multiply and restoring divide, plus sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, mag_b_q};
        div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        fix_res  = !op_q[2] ? ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                 : op_q[1]  ? (sa_q ? -rem : rem)
                 : dz_q     ? '1
                 : ((sa_q ^ sb_q) ? -quo : quo);
    end

    // Next-state: flush wins, then accept, then CALC/FIX/DONE sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            op_d    = op;
            mag_a_d = mag_a_in;
            mag_b_d = mag_b_in;
            sa_d    = sgn_a_in;
            sb_d    = sgn_b_in;
            dz_d    = (b == '0);
            acc_d   = {{XLEN{1'b0}}, op[2] ? mag_a_in : mag_b_in};
        end else if (state_q == S_CALC) begin
            acc_d   = op_q[2] ? div_next : mul_next;
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? S_FIX : S_CALC;
        end else if (state_q == S_FIX) begin
            result_d = fix_res;
            state_d  = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table, random ops against an arithmetic model, and control corner cases
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic definitions
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'(int'(x));
        longint      sy = longint'(int'(y));
        longint      uy = longint'({32'b0, y});
        logic [63:0] p;
        int          ix = int'(x);
        int          iy = int'(y);
        logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        logic [31:0] r;
        case (o)
            3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
            3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
            3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            3'd4: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: r = (y == 0) ? x : ovf ? 32'd0 : 32'(ix % iy);
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Issue one op at the next falling edge; lat counts edges after the accept edge until done
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output int bcnt);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            bcnt += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        r = result;
    endtask

    vec_t        vecs[14];
    logic [31:0] r, last_exp, e;
    int          lat, bcnt, dcnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{"mul_7xm3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{"div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{"rem_m5_0",      3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[13] = '{"divu_5_0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt);
            chk(vecs[i].name, r, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd33);
            if (i == 0) chk("busy_cycles", 32'(bcnt), 32'd33);
            last_exp = vecs[i].exp;
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            e  = model(ro, ra, rb);
            run_op(ro, ra, rb, r, lat, bcnt);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), r, e);
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'd33);
            last_exp = e;
        end

        // Back-to-back: run_op returns in the DONE cycle, so the next issue lands there
        chk("b2b_in_done", 32'(done), 32'd1);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, r, lat, bcnt);
        chk("b2b_mulh", r, 32'hFFFF_FFFF);
        chk("b2b_lat", 32'(lat), 32'd33);
        last_exp = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_held", result, last_exp);

        // Start during CALC is ignored
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            if (lat == 5) begin start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("ignored_start_res", result, 32'd14);
        chk("ignored_start_lat", 32'(lat), 32'd33);
        last_exp = 32'd14;
        @(posedge clk); #1;
        chk("ignored_start_no_restart", 32'(busy), 32'd0);

        // Flush at iteration 10
        @(negedge clk);
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, last_exp);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        chk("flush_no_done", 32'(dcnt), 32'd0);
        chk("flush_result_late", result, last_exp);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op = 3'd1; a = 32'h1234_5678; b = 32'h0FED_CBA9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bcnt);
        chk("post_rst_mulhu", r, 32'hFFFF_FFFE);
        chk("post_rst_lat", 32'(lat), 32'd33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
